// File: rtl/pcie_framing_pkg.sv
// Shared PCIe framing definitions: K-symbol codes, the framer state encoding and source-select codes.
// The receive-side byte classifier imports the same symbol constants.
package pcie_framing_pkg;

    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;
    localparam logic [7:0] SYM_PAD = 8'hF7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TAIL    = 2'd2
    } framer_state_t;

    typedef enum logic [1:0] {
        SRC_TLP  = 2'b01,
        SRC_DLLP = 2'b10
    } src_sel_t;

endpackage

// File: rtl/tx_framer.sv
// Transmit framer: wraps one TLP (STP..END/EDB) or DLLP (SDP..END) per packet into a registered symbol stream.
// Optional macro TX_FRAMER_PAD_FILL_EN fills idle cycles with PAD K-symbols instead of tx_valid=0.
module tx_framer
    import pcie_framing_pkg::*;
#(
    parameter int MAX_TLP_BYTES = 4096,
    parameter int DLLP_BYTES    = 6,
    parameter int CNT_W         = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tlp_valid,
    input  logic [7:0] tlp_data,
    input  logic       tlp_last,
    input  logic       tlp_nullify,
    output logic       tlp_ready,
    input  logic       dllp_valid,
    input  logic [7:0] dllp_data,
    output logic       dllp_ready,
    output logic [7:0] tx_byte,
    output logic       tx_dk,
    output logic       tx_valid,
    output logic       tx_abort
);

`ifdef TX_FRAMER_PAD_FILL_EN
    localparam logic [7:0] IDLE_BYTE  = SYM_PAD;
    localparam logic       IDLE_DK    = 1'b1;
    localparam logic       IDLE_VALID = 1'b1;
`else
    localparam logic [7:0] IDLE_BYTE  = 8'h00;
    localparam logic       IDLE_DK    = 1'b0;
    localparam logic       IDLE_VALID = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX_TLP   = CNT_W'(MAX_TLP_BYTES);
    localparam logic [CNT_W-1:0] CNT_DLLP_LAST = CNT_W'(DLLP_BYTES - 1);

    framer_state_t    state_q, state_d;
    src_sel_t         sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tail_q, tail_d;
    logic [7:0]       byte_d;
    logic             dk_d, valid_d, abort_d;

    // Readys depend only on registered state so no valid->ready loop can form upstream.
    assign tlp_ready  = (state_q == ST_PAYLOAD) && (sel_q == SRC_TLP);
    assign dllp_ready = (state_q == ST_PAYLOAD) && (sel_q == SRC_DLLP);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        tail_d  = tail_q;
        byte_d  = IDLE_BYTE;
        dk_d    = IDLE_DK;
        valid_d = IDLE_VALID;
        abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dllp_valid) begin
                    {byte_d, dk_d, valid_d} = {SYM_SDP, 1'b1, 1'b1};
                    sel_d   = SRC_DLLP;
                    cnt_d   = '0;
                    state_d = ST_PAYLOAD;
                end else if (tlp_valid) begin
                    {byte_d, dk_d, valid_d} = {SYM_STP, 1'b1, 1'b1};
                    sel_d   = SRC_TLP;
                    cnt_d   = '0;
                    state_d = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                // Default outcome is the abort path; accepted bytes override it below.
                {byte_d, dk_d, valid_d} = {SYM_EDB, 1'b1, 1'b1};
                abort_d = 1'b1;
                state_d = ST_IDLE;
                if (sel_q == SRC_DLLP) begin
                    if (dllp_valid) begin
                        {byte_d, dk_d, abort_d} = {dllp_data, 1'b0, 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_PAYLOAD;
                        if (cnt_q == CNT_DLLP_LAST) begin
                            tail_d  = SYM_END;
                            state_d = ST_TAIL;
                        end
                    end
                end else if (tlp_valid && !(cnt_q == CNT_MAX_TLP && !tlp_last)) begin
                    {byte_d, dk_d, abort_d} = {tlp_data, 1'b0, 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_PAYLOAD;
                    if (tlp_last) begin
                        tail_d  = tlp_nullify ? SYM_EDB : SYM_END;
                        state_d = ST_TAIL;
                    end
                end
            end

            ST_TAIL: begin
                {byte_d, dk_d, valid_d} = {tail_q, 1'b1, 1'b1};
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= SRC_TLP;
            cnt_q    <= '0;
            tail_q   <= SYM_END;
            tx_byte  <= 8'h00;
            tx_dk    <= 1'b0;
            tx_valid <= 1'b0;
            tx_abort <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            tail_q   <= tail_d;
            tx_byte  <= byte_d;
            tx_dk    <= dk_d;
            tx_valid <= valid_d;
            tx_abort <= abort_d;
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// Table-driven bench for tx_framer (MAX_TLP_BYTES overridden to 4 to reach overflow quickly).
// Each vector is one clock: inputs, expected readys in that cycle, expected registered outputs after the edge.
module tb_tx_framer;

`ifdef TX_FRAMER_PAD_FILL_EN
    localparam logic [7:0] IB = 8'hF7;
    localparam logic       IK = 1'b1;
    localparam logic       IV = 1'b1;
`else
    localparam logic [7:0] IB = 8'h00;
    localparam logic       IK = 1'b0;
    localparam logic       IV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tlp_valid = 1'b0, tlp_last = 1'b0, tlp_nullify = 1'b0;
    logic [7:0] tlp_data = 8'h00;
    logic       dllp_valid = 1'b0;
    logic [7:0] dllp_data = 8'h00;
    logic       tlp_ready, dllp_ready;
    logic [7:0] tx_byte;
    logic       tx_dk, tx_valid, tx_abort;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_framer #(.MAX_TLP_BYTES(4), .DLLP_BYTES(6), .CNT_W(13)) dut (
        .clk(clk), .rst(rst),
        .tlp_valid(tlp_valid), .tlp_data(tlp_data), .tlp_last(tlp_last),
        .tlp_nullify(tlp_nullify), .tlp_ready(tlp_ready),
        .dllp_valid(dllp_valid), .dllp_data(dllp_data), .dllp_ready(dllp_ready),
        .tx_byte(tx_byte), .tx_dk(tx_dk), .tx_valid(tx_valid), .tx_abort(tx_abort)
    );

    typedef struct {
        logic       tv, tl, tn, dv;
        logic [7:0] td, dd;
        logic       tr, dr;
        logic       ov, ok, oa;
        logic [7:0] ob;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic tv, logic [7:0] td, logic tl, logic tn,
                                logic dv, logic [7:0] dd, logic tr, logic dr,
                                logic ov, logic [7:0] ob, logic ok, logic oa);
        vec_t v;
        v.tv = tv; v.td = td; v.tl = tl; v.tn = tn; v.dv = dv; v.dd = dd;
        v.tr = tr; v.dr = dr; v.ov = ov; v.ob = ob; v.ok = ok; v.oa = oa;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        tlp_valid = 1'b0; tlp_data = 8'h00; tlp_last = 1'b0; tlp_nullify = 1'b0;
        dllp_valid = 1'b0; dllp_data = 8'h00;
    endtask

    // Outputs packed as {valid, dk, abort, byte}.
    function automatic logic [31:0] outs();
        return {21'd0, tx_valid, tx_dk, tx_abort, tx_byte};
    endfunction

    initial begin
        // TLP A1 A2 A3 -> FB A1 A2 A3 FD
        vecs.push_back(mk(1, 8'hA1, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFB, 1, 0));
        vecs.push_back(mk(1, 8'hA1, 0, 0, 0, 8'h00, 1, 0, 1, 8'hA1, 0, 0));
        vecs.push_back(mk(1, 8'hA2, 0, 0, 0, 8'h00, 1, 0, 1, 8'hA2, 0, 0));
        vecs.push_back(mk(1, 8'hA3, 1, 0, 0, 8'h00, 1, 0, 1, 8'hA3, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFD, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, IV, IB, IK, 0));
        // DLLP 00..05 -> 5C 00..05 FD, dllp_ready high exactly six cycles
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 1, 8'h5C, 1, 0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'(i), 0, 1, 1, 8'(i), 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFD, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, IV, IB, IK, 0));
        // Simultaneous request: DLLP 10..15 first, then one-byte TLP D0
        vecs.push_back(mk(1, 8'hD0, 1, 0, 1, 8'h10, 0, 0, 1, 8'h5C, 1, 0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1, 8'hD0, 1, 0, 1, 8'(8'h10 + i), 0, 1, 1, 8'(8'h10 + i), 0, 0));
        vecs.push_back(mk(1, 8'hD0, 1, 0, 0, 8'h00, 0, 0, 1, 8'hFD, 1, 0));
        vecs.push_back(mk(1, 8'hD0, 1, 0, 0, 8'h00, 0, 0, 1, 8'hFB, 1, 0));
        vecs.push_back(mk(1, 8'hD0, 1, 0, 0, 8'h00, 1, 0, 1, 8'hD0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFD, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, IV, IB, IK, 0));
        // Nullified TLP B0 B1 -> FB B0 B1 FE, no abort pulse
        vecs.push_back(mk(1, 8'hB0, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFB, 1, 0));
        vecs.push_back(mk(1, 8'hB0, 0, 0, 0, 8'h00, 1, 0, 1, 8'hB0, 0, 0));
        vecs.push_back(mk(1, 8'hB1, 1, 1, 0, 8'h00, 1, 0, 1, 8'hB1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFE, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, IV, IB, IK, 0));
        // Underrun after C0 C1 -> FB C0 C1 FE with abort pulse
        vecs.push_back(mk(1, 8'hC0, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFB, 1, 0));
        vecs.push_back(mk(1, 8'hC0, 0, 0, 0, 8'h00, 1, 0, 1, 8'hC0, 0, 0));
        vecs.push_back(mk(1, 8'hC1, 0, 0, 0, 8'h00, 1, 0, 1, 8'hC1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 8'hFE, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, IV, IB, IK, 0));
        // Overflow at MAX_TLP_BYTES=4: fifth non-last byte dropped, EDB + abort
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFB, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 8'(8'hE0 + i), 0, 0, 0, 8'h00, 1, 0, 1, 8'(8'hE0 + i), 0, 0));
        vecs.push_back(mk(1, 8'hE4, 0, 0, 0, 8'h00, 1, 0, 1, 8'hFE, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, IV, IB, IK, 0));
        // Exactly MAX bytes with last on the fourth is a normal END
        vecs.push_back(mk(1, 8'h70, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFB, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 8'(8'h70 + i), logic'(i == 3), 0, 0, 8'h00, 1, 0, 1, 8'(8'h70 + i), 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'hFD, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, IV, IB, IK, 0));
        // DLLP underrun after two bytes
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h20, 0, 0, 1, 8'h5C, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h20, 0, 1, 1, 8'h20, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h21, 0, 1, 1, 8'h21, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1, 8'hFE, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, IV, IB, IK, 0));

        // Reset state while rst is held
        #12;
        check("reset_outs", outs(), {21'd0, 3'b000, 8'h00});
        check("reset_readys", {30'd0, tlp_ready, dllp_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_idle", outs(), {21'd0, IV, IK, 1'b0, IB});

        foreach (vecs[n]) begin
            tlp_valid = vecs[n].tv; tlp_data = vecs[n].td; tlp_last = vecs[n].tl;
            tlp_nullify = vecs[n].tn; dllp_valid = vecs[n].dv; dllp_data = vecs[n].dd;
            #1;
            check($sformatf("vec%0d_readys", n), {30'd0, tlp_ready, dllp_ready},
                  {30'd0, vecs[n].tr, vecs[n].dr});
            @(posedge clk); #1;
            check($sformatf("vec%0d_outs", n), outs(),
                  {21'd0, vecs[n].ov, vecs[n].ok, vecs[n].oa, vecs[n].ob});
        end

        // Reset mid-packet: outputs clear immediately, no END/EDB afterwards
        tlp_valid = 1'b1; tlp_data = 8'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midpkt_byte", outs(), {21'd0, 3'b100, 8'h55});
        #2 rst = 1'b1;
        #1;
        check("async_reset_outs", outs(), {21'd0, 3'b000, 8'h00});
        check("async_reset_readys", {30'd0, tlp_ready, dllp_ready}, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", outs(), {21'd0, IV, IK, 1'b0, IB});
        @(posedge clk); #1;
        check("post_reset_idle2", outs(), {21'd0, IV, IK, 1'b0, IB});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
